// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared state encoding and screen-select constants for the pinball game flow.
package game_flow_pkg;
  typedef enum logic [2:0] {S_WELCOME, S_PLAY, S_PAUSE, S_GAME_OVER, S_WIN} game_state_t;
  localparam logic [1:0] SCR_WELCOME = 2'd0;
  localparam logic [1:0] SCR_GAME    = 2'd1;
  localparam logic [1:0] SCR_END     = 2'd2;
  function automatic logic is_end(input game_state_t s);
    return s == S_GAME_OVER || s == S_WIN;
  endfunction
endpackage

// File: rtl/game_timeout_counter.sv
// game_timeout_counter: counts enabled cycles; done flags the cycle the count equals LIMIT-1.
module game_timeout_counter #(
  parameter int WIDTH = 26,
  parameter int LIMIT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);
  logic [WIDTH-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
  assign done = enable && cnt_q == WIDTH'(LIMIT - 1);
endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: welcome/play/pause/game-over/win FSM owning lives and levels.
// Optional PAUSE state is built when GAME_FLOW_PAUSE_EN is defined.
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int LIFE_W      = 4,
  parameter int START_LIVES = 3,
  parameter int LEVELS      = 4,
  parameter int END_TIMEOUT = 50000000,
  localparam int LVL_W      = LEVELS > 1 ? $clog2(LEVELS) : 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              key0IsPressed,
  input  logic              key1IsPressed,
  input  logic              ballLost,
  input  logic              levelCleared,
  output logic              start,
  output logic              gameEnd,
  output logic              win,
  output logic              paused,
  output logic              screenWelcomeOperational,
  output logic [LIFE_W-1:0] life,
  output logic [LVL_W-1:0]  level
);
  localparam int TO_W = END_TIMEOUT > 1 ? $clog2(END_TIMEOUT) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIVES0 = LIFE_W'(START_LIVES);
  game_state_t state_q, state_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic start_q, game_end_q, win_q, welcome_q;
  logic in_end, to_done;
  assign in_end = is_end(state_q);
  game_timeout_counter #(.WIDTH(TO_W), .LIMIT(END_TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (resetN),
    .clear (!in_end),
    .enable(in_end),
    .done  (to_done)
  );
  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    level_d = level_q;
    case (state_q)
      S_WELCOME:
        if (key0IsPressed) begin
          state_d = S_PLAY;
          life_d  = LIVES0;
          level_d = '0;
        end
      S_PLAY: begin
        // A lost ball outranks a cleared level arriving in the same cycle
        if (ballLost) begin
          life_d  = life_q == '0 ? life_q : life_q - 1'b1;
          state_d = life_q <= LIFE_W'(1) ? S_GAME_OVER : S_PLAY;
        end else if (levelCleared) begin
          state_d = level_q == LVL_MAX ? S_WIN : S_PLAY;
          level_d = level_q == LVL_MAX ? level_q : level_q + 1'b1;
        end
`ifdef GAME_FLOW_PAUSE_EN
        if (key1IsPressed && state_d == S_PLAY) state_d = S_PAUSE;
`endif
      end
`ifdef GAME_FLOW_PAUSE_EN
      S_PAUSE:
        state_d = key1IsPressed ? S_WELCOME : key0IsPressed ? S_PLAY : S_PAUSE;
`endif
      S_GAME_OVER, S_WIN:
        if (key1IsPressed || to_done) state_d = S_WELCOME;
      default: state_d = S_WELCOME;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q    <= S_WELCOME;
      life_q     <= LIVES0;
      level_q    <= '0;
      start_q    <= 1'b0;
      game_end_q <= 1'b0;
      win_q      <= 1'b0;
      welcome_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      life_q     <= life_d;
      level_q    <= level_d;
      start_q    <= state_d != S_WELCOME;
      game_end_q <= is_end(state_d);
      win_q      <= state_d == S_WIN;
      welcome_q  <= state_d == S_WELCOME;
    end
`ifdef GAME_FLOW_PAUSE_EN
  logic paused_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) paused_q <= 1'b0;
    else paused_q <= state_d == S_PAUSE;
  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif
  assign start                    = start_q;
  assign gameEnd                  = game_end_q;
  assign win                      = win_q;
  assign screenWelcomeOperational = welcome_q;
  assign life                     = life_q;
  assign level                    = level_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed scenarios plus random pulses checked against a behavioural model.
module tb_game_flow_controller;
  localparam int LIFE_W = 4, START_LIVES = 3, LEVELS = 4, END_TIMEOUT = 10;
`ifdef GAME_FLOW_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  logic clk = 1'b0, resetN = 1'b0;
  logic k0 = 1'b0, k1 = 1'b0, bl = 1'b0, lc = 1'b0;
  logic start, game_end, win, paused, welcome;
  logic [LIFE_W-1:0] life;
  logic [1:0] level;
  int total = 0, bad = 0;
  byte m_mode;
  int m_life, m_level, m_t;
  always #5 clk = ~clk;
  game_flow_controller #(
    .LIFE_W(LIFE_W), .START_LIVES(START_LIVES), .LEVELS(LEVELS), .END_TIMEOUT(END_TIMEOUT)
  ) dut (
    .clk(clk), .resetN(resetN), .key0IsPressed(k0), .key1IsPressed(k1),
    .ballLost(bl), .levelCleared(lc), .start(start), .gameEnd(game_end), .win(win),
    .paused(paused), .screenWelcomeOperational(welcome), .life(life), .level(level)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = "W";
    m_life = START_LIVES;
    m_level = 0;
    m_t = 0;
  endtask
  task automatic model_step(input bit a, input bit b, input bit c, input bit d);
    case (m_mode)
      "W": if (a) begin m_mode = "P"; m_life = START_LIVES; m_level = 0; end
      "P": begin
        if (c) begin
          if (m_life > 0) m_life--;
          if (m_life == 0) m_mode = "O";
        end else if (d) begin
          if (m_level < LEVELS - 1) m_level++;
          else m_mode = "V";
        end
        if (PAUSE_EN && b && m_mode == "P") m_mode = "Z";
      end
      "Z": if (b) m_mode = "W"; else if (a) m_mode = "P";
      default: begin
        if (b || m_t == END_TIMEOUT - 1) m_mode = "W";
        m_t = m_mode == "W" ? 0 : m_t + 1;
      end
    endcase
  endtask
  task automatic check_all();
    check("start", start, m_mode != "W");
    check("gameEnd", game_end, m_mode == "O" || m_mode == "V");
    check("win", win, m_mode == "V");
    check("paused", paused, m_mode == "Z");
    check("welcome", welcome, m_mode == "W");
    check("life", life, m_life);
    check("level", level, m_level);
  endtask
  task automatic cycle(input bit a, input bit b, input bit c, input bit d);
    k0 = a; k1 = b; bl = c; lc = d;
    @(posedge clk);
    model_step(a, b, c, d);
    @(negedge clk);
    k0 = 0; k1 = 0; bl = 0; lc = 0;
    check_all();
  endtask
  task automatic async_reset();
    resetN = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    resetN = 1'b1;
  endtask
  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("rst_welcome", welcome, 1);
    resetN = 1'b1;
    cycle(1, 0, 0, 0);
    check("go_start", start, 1);
    check("go_welcome", welcome, 0);
    check("go_life", life, 3);
    check("go_level", level, 0);
    cycle(0, 0, 0, 1);
    check("lvl1", level, 1);
    cycle(0, 0, 1, 0);
    check("life2", life, 2);
    cycle(0, 0, 1, 1);
    check("both_life", life, 1);
    check("both_level", level, 1);
    cycle(0, 0, 1, 0);
    check("over_life", life, 0);
    check("over_end", game_end, 1);
    check("over_win", win, 0);
    n = 1;
    cycle(0, 0, 1, 0);
    check("no_wrap", life, 0);
    if (game_end) n++;
    for (int i = 0; i < 20 && game_end; i++) begin
      cycle(0, 0, 0, 0);
      if (game_end) n++;
    end
    check("timeout_len", n, END_TIMEOUT);
    check("timeout_welcome", welcome, 1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      check("lvl_step", level, i < 3 ? i + 1 : 3);
    end
    check("win_win", win, 1);
    check("win_end", game_end, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("key1_welcome", welcome, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("pause_on", paused, PAUSE_EN);
    cycle(0, 0, 1, 0);
    check("pause_life", life, PAUSE_EN ? 3 : 2);
    cycle(1, 0, 0, 0);
    check("pause_off", paused, 0);
    cycle(0, 0, 0, 1);
    async_reset();
    check("async_welcome", welcome, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) async_reset();
      else cycle($urandom_range(7) == 0, $urandom_range(11) == 0,
                 $urandom_range(5) == 0, $urandom_range(4) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
